// File: rtl/prio_enc_queue.sv
// prio_enc_queue: registered priority encoder with a sticky pending register.
// Request pulses on I are latched into P. The highest-priority pending index
// is issued through a valid/ready port (Y/VALID). The issued bit is cleared
// from P when it is issued, so simultaneous or stalled requests are not lost.
// OVF pulses for one cycle when a request lands on a bit that is already pending.
// Build option: define PRIO_ENC_ROUND_ROBIN_EN for rotating (round-robin)
// priority. Without it, priority is fixed MSB-first.
module prio_enc_queue #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [N-1:0] I,
  input  logic         READY,
  output logic [W-1:0] Y,
  output logic         VALID,
  output logic [N-1:0] PEND,
  output logic         OVF
);

  logic [N-1:0] p_q, p_d;
  logic [N-1:0] clr_mask;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] sel;
  logic         valid_q, valid_d;
  logic         ovf_q, ovf_d;
  logic         issue;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0] r_q, r_d;

  // Round-robin select: scan from lowest to highest priority so the last hit wins.
  // The lowest-priority segment is R..N-1 (ascending), followed by 0..R-1.
  // The final order is therefore R-1 down to 0, then N-1 down to R.
  always_comb begin
    // NOTE: every signal driven in a combinational block gets a default
    // before any conditional assignment; otherwise a latch is inferred.
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (p_q[i] && (W'(i) >= r_q)) sel = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (p_q[i] && (W'(i) < r_q)) sel = W'(i);
    end
  end
`else
  // Fixed select: scan in ascending order so the highest pending index wins.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (p_q[i]) sel = W'(i);
    end
  end
`endif

  // Next-state logic: issue handshake, clear-then-set of P, and overflow detection.
  always_comb begin
    issue    = EN & (|p_q) & (~valid_q | READY);
    clr_mask = '0;
    if (issue) clr_mask[sel] = 1'b1;

    p_d     = p_q;
    y_d     = y_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;

    // The new request is ORed in after the clear, so a request arriving on
    // the bit being issued keeps that bit pending for a later issue.
    if (EN) begin
      p_d   = (p_q & ~clr_mask) | I;
      ovf_d = |(I & p_q);
    end

    if (issue) begin
      y_d     = sel;
      valid_d = 1'b1;
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

`ifdef PRIO_ENC_ROUND_ROBIN_EN
  // Pointer update: remember the last issued index so it drops to lowest priority.
  always_comb begin
    r_d = r_q;
    if (issue) r_d = sel;
  end
`endif

  // State registers with synchronous reset; RST discards all pending and unconsumed work.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the statement order.
    if (RST) begin
      p_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      r_q     <= '0;
`endif
    end else begin
      p_q     <= p_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      r_q     <= r_d;
`endif
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign PEND  = p_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Testbench for prio_enc_queue (N = 8).
// Part 1 is a table of directed vectors with hand-computed expected outputs.
// Part 2 is a sustained-load sequence.
// Part 3 drives random stimulus against a queue/array reference model.
// The model follows PRIO_ENC_ROUND_ROBIN_EN in the same way as the design.
module tb_prio_enc_queue;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         CLK = 1'b0;
  logic         RST;
  logic         EN;
  logic [N-1:0] I;
  logic         READY;
  logic [W-1:0] Y;
  logic         VALID;
  logic [N-1:0] PEND;
  logic         OVF;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  prio_enc_queue #(.N(N)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .I     (I),
    .READY (READY),
    .Y     (Y),
    .VALID (VALID),
    .PEND  (PEND),
    .OVF   (OVF)
  );

  // Each vector holds the inputs applied before an edge and the outputs
  // expected just after that edge.
  typedef struct {
    logic         rst;
    logic         en;
    logic         ready;
    logic [N-1:0] i;
    logic [W-1:0] y;
    logic         valid;
    logic [N-1:0] pend;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic en, input logic ready,
                              input logic [N-1:0] i, input logic [W-1:0] y,
                              input logic valid, input logic [N-1:0] pend,
                              input logic ovf);
    vec_t v;
    v.rst = rst; v.en = en; v.ready = ready; v.i = i;
    v.y = y; v.valid = valid; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] ey, input logic ev,
                           input logic [N-1:0] ep, input logic eo);
    check({tag, ".VALID"}, 32'(VALID), 32'(ev));
    check({tag, ".Y"},     32'(Y),     32'(ey));
    check({tag, ".PEND"},  32'(PEND),  32'(ep));
    check({tag, ".OVF"},   32'(OVF),   32'(eo));
  endtask

  task automatic drive(input logic rst, input logic en, input logic ready, input logic [N-1:0] i);
    RST = rst; EN = en; READY = ready; I = i;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  bit m_pend[N];
  bit m_valid;
  bit m_ovf;
  int m_y;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
  int m_r;
`endif

  // Return the first pending index in priority order, or -1 if none is pending.
  function automatic int pick();
    int order[$];
`ifdef PRIO_ENC_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) order.push_back((m_r - k + N) % N);
`else
    for (int k = N - 1; k >= 0; k--) order.push_back(k);
`endif
    foreach (order[j]) if (m_pend[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit ready, input logic [N-1:0] i);
    bit any;
    bit ov;
    int s;
    if (rst) begin
      foreach (m_pend[k]) m_pend[k] = 1'b0;
      m_valid = 1'b0; m_ovf = 1'b0; m_y = 0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      m_r = 0;
`endif
      return;
    end
    any = 1'b0;
    ov  = 1'b0;
    for (int k = 0; k < N; k++) begin
      any |= m_pend[k];
      if (en && i[k] && m_pend[k]) ov = 1'b1;
    end
    if (en && any && (!m_valid || ready)) begin
      s = pick();
      m_y = s;
      m_valid = 1'b1;
      m_pend[s] = 1'b0;
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      m_r = s;
`endif
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (en) for (int k = 0; k < N; k++) if (i[k]) m_pend[k] = 1'b1;
    m_ovf = ov;
  endtask

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_pend[k];
    return v;
  endfunction

  initial begin
    logic [N-1:0] iv;
    bit rb, eb, yb;

    // ---------------- part 1: directed vector table ----------------
    //   rst en rdy i           y  valid pend        ovf
    add(1, 0, 0, 8'h00,       0, 0, 8'h00, 0);  // reset state
    // Single request
    add(0, 1, 1, 8'h80,       0, 0, 8'h80, 0);  // captured into P
    add(0, 1, 1, 8'h00,       7, 1, 8'h00, 0);  // issued
    add(0, 1, 1, 8'h00,       7, 0, 8'h00, 0);  // consumed, Y holds
    // Burst, no loss
    add(0, 1, 1, 8'h24,       7, 0, 8'h24, 0);
    add(0, 1, 1, 8'h00,       5, 1, 8'h04, 0);
    add(0, 1, 1, 8'h00,       2, 1, 8'h00, 0);
    add(0, 1, 1, 8'h00,       2, 0, 8'h00, 0);
    // Stall and overflow
    add(0, 1, 0, 8'h40,       2, 0, 8'h40, 0);
    add(0, 1, 0, 8'h00,       6, 1, 8'h00, 0);
    add(0, 1, 0, 8'h08,       6, 1, 8'h08, 0);
    add(0, 1, 0, 8'h08,       6, 1, 8'h08, 1);  // hit on pending bit
    add(0, 1, 0, 8'h00,       6, 1, 8'h08, 0);  // one-cycle pulse
    add(0, 1, 1, 8'h00,       3, 1, 8'h00, 0);
    add(0, 1, 1, 8'h00,       3, 0, 8'h00, 0);
    // Enable gating
    for (int k = 0; k < 5; k++) add(0, 0, 1, 8'hFF, 3, 0, 8'h00, 0);
    add(0, 1, 1, 8'h00,       3, 0, 8'h00, 0);
    add(0, 1, 1, 8'h00,       3, 0, 8'h00, 0);
    // Handshake completes while EN=0
    add(0, 1, 0, 8'h01,       3, 0, 8'h01, 0);
    add(0, 1, 0, 8'h00,       0, 1, 8'h00, 0);
    add(0, 0, 0, 8'h00,       0, 1, 8'h00, 0);
    add(0, 0, 1, 8'h00,       0, 0, 8'h00, 0);
    // Reset mid-operation (issue with set-wins on bit 7 beforehand)
    add(0, 1, 0, 8'hF0,       0, 0, 8'hF0, 0);
    add(0, 1, 0, 8'hF0,       7, 1, 8'hF0, 1);
    add(1, 1, 0, 8'h00,       0, 0, 8'h00, 0);
    add(0, 1, 1, 8'h00,       0, 0, 8'h00, 0);
    add(0, 1, 1, 8'h00,       0, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].en, vecs[k].ready, vecs[k].i);
      tick();
      check_out($sformatf("vec%0d", k), vecs[k].y, vecs[k].valid, vecs[k].pend, vecs[k].ovf);
    end

    // ---------------- part 2: sustained load ----------------
    drive(1, 0, 0, 8'h00);
    tick();
    drive(0, 1, 1, 8'hFF);
    tick();
    check_out("sus0", 0, 0, 8'hFF, 0);
    for (int k = 1; k <= 17; k++) begin
      tick();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
      check_out($sformatf("sus%0d", k), W'(7 - ((k - 1) % 8)), 1, 8'hFF, 1);
`else
      check_out($sformatf("sus%0d", k), W'(7), 1, 8'hFF, 1);
`endif
    end

    // ---------------- part 3: random vs. reference model ----------------
    drive(1, 0, 0, 8'h00);
    model_step(1, 0, 0, 8'h00);
    tick();
    for (int c = 0; c < 2000; c++) begin
      rb = ($urandom_range(0, 199) == 0);
      eb = ($urandom_range(0, 7) != 0);
      yb = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++) iv[k] = ($urandom_range(0, 6) == 0);
      drive(rb, eb, yb, iv);
      model_step(rb, eb, yb, iv);
      tick();
      check_out($sformatf("rnd%0d", c), W'(m_y), m_valid, m_pend_vec(), m_ovf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_enc_queue.md
# prio_enc_queue

Parametrised, registered successor to the combinational 8-to-3 priority encoder. It latches request pulses on N input lines into a sticky pending register and issues the index of the highest-priority pending request through a valid/ready output port. The granted bit is cleared on issue, so no request is lost, even when several requests arrive together or the consumer stalls. It sits between interrupt/event sources and a single consumer such as a controller FSM or a DMA sequencer.

## Interface
- N, default 8: number of request lines; legal range 2..256.
- W, default $clog2(N): index width; derived, not to be overridden.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  block enable; gates request capture and index issue.
- I  in  N  request lines; each bit high for one or more cycles sets its pending bit.
- READY  in  1  consumer accepts Y this cycle when VALID is also high.
- Y  out  W  issued request index; held stable while VALID=1 and READY=0.
- VALID  out  1  Y holds an unconsumed index.
- PEND  out  N  pending register, excluding the index currently held in Y.
- OVF  out  1  one-cycle pulse: a request hit a bit that was already pending.

The block has one clock, CLK. RST is synchronous and active-high.

## Operation
- State:
  - Pending register P[N-1:0].
  - Output register {Y, VALID}.
  - OVF flag.
  - Round-robin pointer R[W-1:0] (only when the macro is defined).
- Selection: sel is the highest-priority set bit of P.
  - Fixed mode: highest index wins (I[N-1] has top priority), matching the original encoder's MSB-first rule.
- Issue condition: L = EN & |P & (~VALID | READY).
- On L:
  - Y <= sel; VALID <= 1.
  - P[sel] is cleared.
- Consume without reissue: if VALID & READY & ~L, then VALID <= 0. Y keeps its last value.
- Capture: when EN=1, P_next = (P & ~clear_mask) | I.
  - Set wins. If I[sel] is high in the cycle sel is issued, P[sel] stays 1 and the request is served again later.
- OVF <= EN & |(I & P). The term uses P before the clear on the same edge.
- EN=0:
  - P and OVF are not updated by I.
  - No new issue; OVF <= 0.
  - A pending VALID still completes its handshake: VALID drops when READY=1.
- Reset values: P=0, Y=0, VALID=0, OVF=0, R=0, PEND=0.
- RST asserted mid-operation discards all pending requests and any unconsumed Y on the next edge, with no partial state.
- I=0 with P=0: VALID falls after the final consume; Y holds its last value. Consumers must not interpret Y when VALID=0.

## Timing
- Latency: I bit high at edge t captures into P at t. It is issued at edge t+1 if the output register is free, so VALID rises one cycle after P.
- Throughput: one index per cycle while READY=1 and P is non-empty.
- Y, VALID, PEND and OVF are all registered; there are no combinational paths from inputs to outputs.
- READY is sampled only on the rising edge of CLK.
- Y must not change while VALID=1 and READY=0.

## Configuration
- Macro PRIO_ENC_ROUND_ROBIN_EN.
- Defined: round-robin selection.
  - After issuing index k, R <= k.
  - The search order is then R-1, R-2, …, 0, N-1, …, R, descending with wrap-around.
  - R resets to 0, so the first search order is N-1 down to 0, identical to fixed mode.
  - R updates only on L.
- Undefined: fixed MSB-first priority. R is not implemented, and sustained high-index requests can starve low indices; this is intended.

## Test plan
- **Single request:** reset, then EN=1, READY=1, I=8'b1000_0000 for one cycle → VALID=1, Y=3'd7 two edges later; VALID=0 on the following edge; PEND=0.
- **Burst, no loss:** I=8'b0010_0100 for one cycle with READY=1 → Y=5 then Y=2 on consecutive cycles with VALID=1 throughout; then VALID=0; OVF stays 0.
- **Stall and overflow:**
  - I[6] pulse with READY=0 → Y=6, VALID=1, held.
  - Second I[3] pulse → PEND=8'b0000_1000.
  - Third I[3] pulse → OVF=1 for exactly one cycle.
  - READY=1 → Y=3 next, then VALID=0.
- **Enable gating:** EN=0, I=8'hFF for 5 cycles → PEND=0, VALID=0, OVF=0. Then EN=1 with I=0 → still idle.
- **Sustained load:** I=8'hFF held, READY=1.
  - Fixed mode → Y=7 every cycle.
  - With PRIO_ENC_ROUND_ROBIN_EN → Y=7,6,5,4,3,2,1,0,7,… and OVF=1 every cycle after the first.
- **Reset mid-operation:** P=8'hF0, VALID=1, Y=7, then RST=1 for one cycle → P=0, VALID=0, Y=0, OVF=0 on that edge. With RST released and I=0, no issue follows.
